priority_encoder_seq: RTL and testbench

//  Registered 8-to-3 encoder, the inverse of the 3-to-8 decoder stage. Latches request

---
 rtl/penc_pkg.sv | 19 +
 rtl/penc_pick.sv | 48 ++++
 rtl/priority_encoder_seq.sv | 122 ++++++++++++
 tb/tb_priority_encoder_seq.sv | 183 ++++++++++++++++++
 4 files changed

// File: rtl/penc_pkg.sv
// Shared definitions for the sequential priority encoder.
// Optional feature macro: PENC_RR_EN (round-robin priority instead of fixed).
package penc_pkg;

  // FSM state encoding
  localparam logic [0:0] S_IDLE  = 1'b0;
  localparam logic [0:0] S_VALID = 1'b1;

  // Index width that never collapses to zero bits
  function automatic int penc_idx_w(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

  // One bit of onehot(idx): high when pos is the selected index
  function automatic logic penc_onehot_bit(input int idx, input int pos);
    return (idx == pos);
  endfunction

endpackage

// File: rtl/penc_pick.sv
// Combinational pick of one set bit from an N-bit vector.
// Default: highest set index wins.
// With PENC_RR_EN defined: search runs downward from (base - 1), wrapping
// from 0 to N-1, so base itself is considered last.
module penc_pick
  import penc_pkg::*;
#(
  parameter int N = 8,
  parameter int W = 3
) (
  input  logic [N-1:0] vec,
`ifdef PENC_RR_EN
  input  logic [W-1:0] base,
`endif
  output logic         found,
  output logic [W-1:0] idx
);

`ifdef PENC_RR_EN
  // Rotated search: k=0 is the first position examined, and it is assigned last so it wins
  always_comb begin
    int pos;
    pos   = 0;
    found = 1'b0;
    idx   = '0;
    for (int k = N - 1; k >= 0; k--) begin
      pos = (int'(base) + N - 1 - k) % N;
      if (vec[pos]) begin
        found = 1'b1;
        idx   = W'(pos);
      end
    end
  end
`else
  // Fixed priority: later (higher) indices overwrite lower ones
  always_comb begin
    found = 1'b0;
    idx   = '0;
    for (int i = 0; i < N; i++) begin
      if (vec[i]) begin
        found = 1'b1;
        idx   = W'(i);
      end
    end
  end
`endif

endmodule

// File: rtl/priority_encoder_seq.sv
// Registered N-to-log2(N) encoder with sticky pending requests and a
// valid/ready output handshake, one index per accepted transfer.
// Optional feature macro: PENC_RR_EN (round-robin priority with a
// last-grant pointer; undefined gives fixed highest-index priority).
module priority_encoder_seq
  import penc_pkg::*;
#(
  parameter  int N = 8,
  localparam int W = penc_idx_w(N)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] req,
  output logic [W-1:0] out_code,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] pending,
  output logic         req_merged
);

  logic [0:0]   state_q, state_d;
  logic         out_valid_q, out_valid_d;
  logic [W-1:0] out_code_q, out_code_d;
  logic [N-1:0] pending_q, pending_d;
  logic         merged_q, merged_d;

  logic         hs;
  logic [N-1:0] clr;
  logic         pick_found;
  logic [W-1:0] pick_idx;

  assign hs = out_valid_q & out_ready;

  // Clear mask: onehot of the code being accepted this cycle
  for (genvar g = 0; g < N; g++) begin : g_clr
    assign clr[g] = hs & penc_onehot_bit(32'(out_code_q), g);
  end

  // Set wins over clear, so a re-request of the accepted bit stays pending
  assign pending_d = (pending_q & ~clr) | req;
  assign merged_d  = |(req & pending_q & ~clr);

`ifdef PENC_RR_EN
  logic [W-1:0] ptr_q, ptr_d, pick_base;

  // The grant happening now becomes the search origin for the next load
  assign pick_base = hs ? out_code_q : ptr_q;
  assign ptr_d     = pick_base;

  penc_pick #(.N(N), .W(W)) u_pick (
    .vec   (pending_d),
    .base  (pick_base),
    .found (pick_found),
    .idx   (pick_idx)
  );

  // Last-grant pointer, moves only on handshake
  always_ff @(posedge clk or posedge rst) begin
    if (rst) ptr_q <= '0;
    else     ptr_q <= ptr_d;
  end
`else
  penc_pick #(.N(N), .W(W)) u_pick (
    .vec   (pending_d),
    .found (pick_found),
    .idx   (pick_idx)
  );
`endif

  // Next-state logic: load a pick when idle or on handshake, hold while stalled
  always_comb begin
    state_d     = state_q;
    out_valid_d = out_valid_q;
    out_code_d  = out_code_q;
    case (state_q)
      S_IDLE: begin
        if (pick_found) begin
          state_d     = S_VALID;
          out_valid_d = 1'b1;
          out_code_d  = pick_idx;
        end
      end
      S_VALID: begin
        if (hs) begin
          if (pick_found) begin
            out_code_d = pick_idx;
          end else begin
            state_d     = S_IDLE;
            out_valid_d = 1'b0;
          end
        end
      end
      default: begin
        state_d     = S_IDLE;
        out_valid_d = 1'b0;
      end
    endcase
  end

  // State and output registers; reset drops pending work and any presented code
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      out_valid_q <= 1'b0;
      out_code_q  <= '0;
      pending_q   <= '0;
      merged_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      out_valid_q <= out_valid_d;
      out_code_q  <= out_code_d;
      pending_q   <= pending_d;
      merged_q    <= merged_d;
    end
  end

  assign out_code   = out_code_q;
  assign out_valid  = out_valid_q;
  assign pending    = pending_q;
  assign req_merged = merged_q;

endmodule

// File: tb/tb_priority_encoder_seq.sv
// Self-checking bench for priority_encoder_seq; follows PENC_RR_EN for the
// round-robin expectations.
module tb_priority_encoder_seq;

  localparam int N = 8;
  localparam int W = 3;

  logic         clk = 1'b0;
  logic         rst;
  logic [N-1:0] req;
  logic [W-1:0] out_code;
  logic         out_valid;
  logic         out_ready;
  logic [N-1:0] pending;
  logic         req_merged;

  int n_err = 0;
  int n_chk = 0;
  int sb[$];

  priority_encoder_seq #(.N(N)) dut (
    .clk        (clk),
    .rst        (rst),
    .req        (req),
    .out_code   (out_code),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .pending    (pending),
    .req_merged (req_merged)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Scoreboard: every accepted transfer must match the next expected code
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      chk("sb_nonempty", int'(sb.size() != 0), 1);
      if (sb.size() != 0) chk("code", int'(out_code), sb.pop_front());
    end
  end

  task automatic cyc(input logic [N-1:0] r, input logic rdy);
    req       = r;
    out_ready = rdy;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst       = 1'b1;
    req       = '0;
    out_ready = 1'b0;
    sb.delete();
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic drain(input string tag);
    int n;
    n = 0;
    while ((sb.size() != 0 || out_valid) && n < 20) begin
      cyc('0, 1'b1);
      n++;
    end
    chk({tag, "_drain"}, sb.size(), 0);
    chk({tag, "_idle"}, int'(out_valid), 0);
    chk({tag, "_pend"}, int'(pending), 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    rst       = 1'b1;
    req       = '0;
    out_ready = 1'b0;
    @(posedge clk);
    #1;
    chk("rst_valid", int'(out_valid), 0);
    chk("rst_code", int'(out_code), 0);
    chk("rst_pend", int'(pending), 0);
    chk("rst_merged", int'(req_merged), 0);
    rst = 1'b0;

    // No requests: ready alone produces no activity
    for (int i = 0; i < 4; i++) begin
      cyc('0, 1'b1);
      chk("quiet_valid", int'(out_valid), 0);
      chk("quiet_pend", int'(pending), 0);
    end

    // Async reset mid-transfer, checked before the next clock edge
    cyc(8'hFF, 1'b0);
    chk("t1_pend_pre", int'(pending), 8'hFF);
    chk("t1_valid_pre", int'(out_valid), 1);
    chk("t1_code_pre", int'(out_code), 7);
    #2 rst = 1'b1;
    #1;
    chk("t1_pend", int'(pending), 0);
    chk("t1_valid", int'(out_valid), 0);
    chk("t1_code", int'(out_code), 0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Single request, one-cycle latency
    do_reset();
    sb.push_back(5);
    cyc(8'h20, 1'b1);
    chk("t2_valid", int'(out_valid), 1);
    chk("t2_code", int'(out_code), 5);
    chk("t2_pend", int'(pending), 8'h20);
    cyc('0, 1'b1);
    chk("t2_valid_off", int'(out_valid), 0);
    chk("t2_pend_off", int'(pending), 0);
    chk("t2_sb", sb.size(), 0);

    // Several bits at once, served back-to-back highest first
    do_reset();
    sb.push_back(7); sb.push_back(4); sb.push_back(0);
    cyc(8'h91, 1'b1);
    drain("t3");

    // Stall: presented code stays put even when a higher request arrives
    do_reset();
    sb.push_back(2); sb.push_back(6);
    cyc(8'h04, 1'b0);
    for (int i = 0; i < 5; i++) begin
      cyc((i == 2) ? 8'h40 : 8'h00, 1'b0);
      chk("t4_hold_code", int'(out_code), 2);
      chk("t4_hold_valid", int'(out_valid), 1);
      chk("t4_merged", int'(req_merged), 0);
    end
    chk("t4_pend", int'(pending), 8'h44);
    drain("t4");

    // Collision with the bit being accepted, then a genuine merge
    do_reset();
    sb.push_back(3); sb.push_back(3);
    cyc(8'h08, 1'b0);
    chk("t5_code", int'(out_code), 3);
    cyc(8'h08, 1'b1);
    chk("t5_pend3", int'(pending[3]), 1);
    chk("t5_valid", int'(out_valid), 1);
    chk("t5_code2", int'(out_code), 3);
    chk("t5_no_merge", int'(req_merged), 0);
    cyc(8'h08, 1'b0);
    chk("t5_merge", int'(req_merged), 1);
    cyc(8'h0C, 1'b0);
    chk("t5_merge_again", int'(req_merged), 1);
    cyc('0, 1'b0);
    chk("t5_merge_pulse", int'(req_merged), 0);
    chk("t5_pend_after", int'(pending), 8'h0C);
    sb.push_back(2);
    drain("t5");

    // Continuous requests on both ends: fairness depends on configuration
    do_reset();
`ifdef PENC_RR_EN
    sb.push_back(7); sb.push_back(0); sb.push_back(7); sb.push_back(0); sb.push_back(7);
`else
    sb.push_back(7); sb.push_back(7); sb.push_back(7); sb.push_back(7); sb.push_back(0);
`endif
    for (int i = 0; i < 4; i++) cyc(8'h81, 1'b1);
    drain("t6");

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
